plru_tree_repl: RTL and testbench

// Parametrised tree-PLRU replacement controller for TLBs/small caches in mms.

---
 rtl/plru_tree_repl_pkg.sv | 17 +
 rtl/plru_tree_repl_victim_sel.sv | 55 +++++
 rtl/plru_tree_repl.sv | 122 ++++++++++++
 tb/tb_plru_tree_repl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_tree_repl_pkg.sv
// ----------------------------------------------------------------------------
// plru_tree_repl_pkg
// Shared definitions for the tree-PLRU replacement controller.
//   PLRU_ENTRIES_DEFAULT : default number of ways/entries (TLB entry count
//                          of the MMU build, 32).
//   plru_state_e         : refill handshake state (idle / refill pending).
// ----------------------------------------------------------------------------
package plru_tree_repl_pkg;

    localparam int unsigned PLRU_ENTRIES_DEFAULT = 32;

    typedef enum logic {
        PLRU_IDLE = 1'b0,
        PLRU_PEND = 1'b1
    } plru_state_e;

endpackage

// File: rtl/plru_tree_repl_victim_sel.sv
// ----------------------------------------------------------------------------
// plru_victim_sel
// Combinational victim selection for the tree-PLRU controller.
//   tree_i      in  ENTRIES  heap-numbered tree bits. Bit n is node n, and
//                            bit 0 is unused.
//   valid_i     in  ENTRIES  per-entry valid bits
//   plru_idx_o  out IDX_W    leaf reached by walking the tree from node 1
//   victim_o    out IDX_W    lowest invalid entry. If every entry is valid,
//                            this is plru_idx_o.
// ----------------------------------------------------------------------------
module plru_victim_sel #(
    parameter int unsigned ENTRIES = 32,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] tree_i,
    input  logic [ENTRIES-1:0] valid_i,
    output logic [IDX_W-1:0]   plru_idx_o,
    output logic [IDX_W-1:0]   victim_o
);

    logic [IDX_W:0]   node;
    logic [IDX_W-1:0] freeIdx;
    logic             freeFound;

    // Walk the tree from the root. At each level, shift the node bit in as
    // the next heap-index bit (0 = left child, 1 = right child). Before each
    // step the node number is below ENTRIES, so its low IDX_W bits address
    // the tree. After the last step those low bits are the leaf index.
    always_comb begin
        node = {{IDX_W{1'b0}}, 1'b1};
        for (int l = 0; l < int'(IDX_W); l++) begin
            node = {node[IDX_W-1:0], tree_i[node[IDX_W-1:0]]};
        end
        plru_idx_o = node[IDX_W-1:0];
    end

    // Generic lowest-zero priority encoder. The loop scans from the top down,
    // so the last invalid entry it finds is the lowest-numbered one.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    // Invalid entries are always preferred over evicting a live one.
    always_comb begin
        victim_o = freeFound ? freeIdx : plru_idx_o;
    end

endmodule

// File: rtl/plru_tree_repl.sv
// ----------------------------------------------------------------------------
// plru_tree_repl
// Tree-PLRU replacement controller for TLBs and small caches. It keeps
// ENTRIES-1 tree bits, updates them on hits and on refills, and picks a
// victim (invalid entries first). The victim is latched for the whole
// request/done refill handshake.
//   clk_i          in   clock
//   rstn_i         in   async active-low reset
//   en_i           in   0 freezes the tree and ignores refill requests
//   flush_i        in   sync clear of the tree and of any pending refill
//   entry_valid_i  in   per-entry valid bits
//   access_vld_i   in   lookup performed this cycle
//   access_hit_i   in   lookup hit
//   access_idx_i   in   index of the entry that hit
//   refill_req_i   in   pulse: allocate a victim
//   refill_done_i  in   pulse: refill written into victim_idx_o
//   victim_vld_o   out  victim latched, refill pending
//   victim_idx_o   out  latched victim index
// ----------------------------------------------------------------------------
module plru_tree_repl
    import plru_tree_repl_pkg::*;
#(
    parameter int unsigned ENTRIES = PLRU_ENTRIES_DEFAULT,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic [ENTRIES-1:0] entry_valid_i,
    input  logic               access_vld_i,
    input  logic               access_hit_i,
    input  logic [IDX_W-1:0]   access_idx_i,
    input  logic               refill_req_i,
    input  logic               refill_done_i,
    output logic               victim_vld_o,
    output logic [IDX_W-1:0]   victim_idx_o
);

    logic [ENTRIES-1:0] tree_q, tree_d;
    plru_state_e        state_q, state_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic [IDX_W-1:0]   selVictim;
    logic [IDX_W-1:0]   plruIdx;

    // Mark idx as recently used. Each node on the root-to-leaf path is set to
    // point at the sibling subtree, away from the direction taken (1 = right).
    function automatic logic [ENTRIES-1:0] touch(input logic [ENTRIES-1:0] t,
                                                 input logic [IDX_W-1:0]   idx);
        logic [IDX_W:0] node;
        node = {{IDX_W{1'b0}}, 1'b1};
        for (int l = int'(IDX_W) - 1; l >= 0; l--) begin
            t[node[IDX_W-1:0]] = ~idx[l];
            node = {node[IDX_W-1:0], idx[l]};
        end
        return t;
    endfunction

    plru_victim_sel #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_sel (
        .tree_i     (tree_q),
        .valid_i    (entry_valid_i),
        .plru_idx_o (plruIdx),
        .victim_o   (selVictim)
    );

    // Next-state logic. Flush overrides everything else.
    // A hit touch is applied before the refill touch, so on shared nodes the
    // refilled entry ends up as the most recent one.
    // The victim is taken from the tree and valid bits present in the
    // request cycle.
    always_comb begin
        tree_d   = tree_q;
        state_d  = state_q;
        victim_d = victim_q;
        if (flush_i) begin
            tree_d   = '0;
            state_d  = PLRU_IDLE;
            victim_d = '0;
        end else begin
            if (access_vld_i && access_hit_i && en_i) begin
                tree_d = touch(tree_d, access_idx_i);
            end
            case (state_q)
                PLRU_IDLE: begin
                    if (refill_req_i && en_i) begin
                        victim_d = selVictim;
                        state_d  = PLRU_PEND;
                    end
                end
                PLRU_PEND: begin
                    if (refill_done_i) begin
                        if (en_i) begin
                            tree_d = touch(tree_d, victim_q);
                        end
                        state_d = PLRU_IDLE;
                    end
                end
                default: state_d = PLRU_IDLE;
            endcase
        end
    end

    // State registers. An async reset drops any refill that is in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tree_q   <= '0;
            state_q  <= PLRU_IDLE;
            victim_q <= '0;
        end else begin
            tree_q   <= tree_d;
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    assign victim_vld_o = (state_q == PLRU_PEND);
    assign victim_idx_o = victim_q;

endmodule

// File: tb/tb_plru_tree_repl.sv
// ----------------------------------------------------------------------------
// tb_plru_tree_repl
// Self-checking bench. It drives a 4-entry and a 32-entry controller with
// shared control inputs and checks both against a tree-PLRU reference model.
// ----------------------------------------------------------------------------
module tb_plru_tree_repl;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        flush;
    logic        accVld;
    logic        accHit;
    logic        req;
    logic        done;
    logic [1:0]  accIdx4;
    logic [4:0]  accIdx32;
    logic [3:0]  valid4;
    logic [31:0] valid32;
    logic        vld4;
    logic [1:0]  idx4;
    logic        vld32;
    logic [4:0]  idx32;

    int checks = 0;
    int errors = 0;

    // Reference model state. Index 0 is the 4-entry DUT and index 1 is the
    // 32-entry DUT. Tree bit n is heap node n.
    bit [63:0] mTree [2];
    bit        mPend [2];
    int        mVidx [2];
    int        mEnt  [2];

    initial begin
        mEnt[0] = 4;
        mEnt[1] = 32;
    end

    plru_tree_repl #(.ENTRIES(4)) dut4 (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .en_i          (en),
        .flush_i       (flush),
        .entry_valid_i (valid4),
        .access_vld_i  (accVld),
        .access_hit_i  (accHit),
        .access_idx_i  (accIdx4),
        .refill_req_i  (req),
        .refill_done_i (done),
        .victim_vld_o  (vld4),
        .victim_idx_o  (idx4)
    );

    plru_tree_repl #(.ENTRIES(32)) dut32 (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .en_i          (en),
        .flush_i       (flush),
        .entry_valid_i (valid32),
        .access_vld_i  (accVld),
        .access_hit_i  (accHit),
        .access_idx_i  (accIdx32),
        .refill_req_i  (req),
        .refill_done_i (done),
        .victim_vld_o  (vld32),
        .victim_idx_o  (idx32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mark idx as most recently used: every node on its path points away.
    function automatic bit [63:0] mTouch(bit [63:0] t, int e, int idx);
        int node = 1;
        for (int l = $clog2(e) - 1; l >= 0; l--) begin
            int b = (idx >> l) & 1;
            t[node] = (b == 0);
            node = 2 * node + b;
        end
        return t;
    endfunction

    // Follow the tree bits from the root down to a leaf.
    function automatic int mWalk(bit [63:0] t, int e);
        int node = 1;
        while (node < e) node = 2 * node + int'(t[node]);
        return node - e;
    endfunction

    // Pick the lowest invalid entry, or the PLRU leaf if every entry is valid.
    function automatic int mCand(bit [31:0] v, int e, bit [63:0] t);
        for (int i = 0; i < e; i++) if (!v[i]) return i;
        return mWalk(t, e);
    endfunction

    // Advance the model one clock using the inputs present at the edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < 2; s++) begin
                mTree[s] = '0;
                mPend[s] = 1'b0;
                mVidx[s] = 0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                bit [63:0] t;
                int hIdx;
                bit [31:0] vv;
                hIdx = (s == 0) ? int'(accIdx4) : int'(accIdx32);
                vv   = (s == 0) ? {28'hFFF_FFFF, valid4} : valid32;
                if (flush) begin
                    mTree[s] = '0;
                    mPend[s] = 1'b0;
                    mVidx[s] = 0;
                end else begin
                    t = mTree[s];
                    if (accVld && accHit && en) t = mTouch(t, mEnt[s], hIdx);
                    if (mPend[s]) begin
                        if (done) begin
                            if (en) t = mTouch(t, mEnt[s], mVidx[s]);
                            mPend[s] = 1'b0;
                        end
                    end else if (req && en) begin
                        mVidx[s] = mCand(vv, mEnt[s], mTree[s]);
                        mPend[s] = 1'b1;
                    end
                    mTree[s] = t;
                end
            end
        end
    end

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare both DUTs against the model. The victim index is checked only
    // while a refill is pending.
    task automatic checkOutput();
        checkVal("vld4", int'(vld4), int'(mPend[0]));
        if (mPend[0]) checkVal("idx4", int'(idx4), mVidx[0]);
        checkVal("vld32", int'(vld32), int'(mPend[1]));
        if (mPend[1]) checkVal("idx32", int'(idx32), mVidx[1]);
    endtask

    // Drive one cycle of inputs after a falling edge, then check at the next
    // falling edge.
    task automatic applyStimulus(input bit e, input bit f, input bit hit, input int hIdx,
                                 input bit r, input bit d,
                                 input bit [3:0] v4, input bit [31:0] v32);
        bit [4:0] hb;
        hb       = 5'(hIdx);
        en       = e;
        flush    = f;
        accVld   = hit;
        accHit   = hit;
        accIdx4  = hb[1:0];
        accIdx32 = hb;
        req      = r;
        done     = d;
        valid4   = v4;
        valid32  = v32;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0; flush = 1'b0; accVld = 1'b0; accHit = 1'b0;
        req = 1'b0; done = 1'b0; accIdx4 = '0; accIdx32 = '0;
        valid4 = 4'hF; valid32 = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        checkVal("reset vld4", int'(vld4), 0);
        checkVal("reset idx4", int'(idx4), 0);
        checkVal("reset vld32", int'(vld32), 0);
        checkVal("reset idx32", int'(idx32), 0);
        rstn = 1'b1;

        // All valid from reset: the walk gives 0. Refilling 0 sets n1=1, n2=1,
        // n3=0, so the next walk lands on 2.
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("first req vld4", int'(vld4), 1);
        checkVal("first req idx4", int'(idx4), 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
        checkVal("done vld4", int'(vld4), 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("tree110 idx4", int'(idx4), 2);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);

        // Hits 0,1,2 leave n1=0 (from 2) and n2=0 (from 1), so the walk gives 0.
        // Refilling 0 and then hitting 3 gives n1=0, n2=1, so the walk gives 1.
        applyStimulus(1, 1, 0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 1, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 1, 1, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 1, 2, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("hits012 idx4", int'(idx4), 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 1, 3, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("hit3 idx4", int'(idx4), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);

        // The lowest invalid entry wins regardless of the tree state.
        applyStimulus(1, 0, 0, 0, 1, 0, 4'b1011, 32'h0000_FFFF);
        checkVal("invalid idx32", int'(idx32), 16);
        checkVal("invalid idx4", int'(idx4), 2);
        applyStimulus(1, 0, 1, 2, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("pend hold idx4", int'(idx4), 2);
        checkVal("pend hold vld4", int'(vld4), 1);
        applyStimulus(1, 0, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
        checkVal("pend done vld4", int'(vld4), 0);

        // Same-cycle hit 0 and done on 1: the refill touch wins, giving n1=1.
        // n3 is still 0 from the flush, so the walk gives 2.
        applyStimulus(1, 1, 0, 0, 0, 0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'b1101, 32'hFFFF_FFFF);
        checkVal("refill1 idx4", int'(idx4), 1);
        applyStimulus(1, 0, 1, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("refill wins idx4", int'(idx4), 2);

        // Flush with a same-cycle done clears everything, so the walk gives 0.
        applyStimulus(1, 1, 0, 0, 0, 1, 4'hF, 32'hFFFF_FFFF);
        checkVal("flush vld4", int'(vld4), 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 4'hF, 32'hFFFF_FFFF);
        checkVal("post flush idx4", int'(idx4), 0);
        checkVal("post flush idx32", int'(idx32), 0);

        // Async reset in the middle of a pending refill.
        #2 rstn = 1'b0;
        #1;
        checkVal("async vld4", int'(vld4), 0);
        checkVal("async idx4", int'(idx4), 0);
        checkVal("async vld32", int'(vld32), 0);
        @(negedge clk);
        checkOutput();
        rstn = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit [3:0]  v4;
            bit [31:0] v32;
            v4  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            v32 = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : ($urandom | $urandom | $urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rstn = 1'b0;
                #1;
                checkVal("rand async vld4", int'(vld4), 0);
                checkVal("rand async vld32", int'(vld32), 0);
                @(negedge clk);
                rstn = 1'b1;
            end
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, v4, v32);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
